// File: rtl/alu_sequencer_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the ALU sequencer slice.
package alu_sequencer_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_SHR = 8'h0D;
  localparam logic [7:0] OP_CMP = 8'h0F;
  localparam logic [7:0] OP_MOV = 8'h80;
  localparam logic [7:0] OP_LDI = 8'hC0;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_P = 3;
  localparam int unsigned FLAG_O = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  function automatic logic is_alu_op(input logic [7:0] op);
    return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_CMP) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two async operand read ports, async debug read,
// one synchronous write port, asynchronous clear.
module alu_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Accepts 24-bit instructions, issues register operands to an external ALU,
// waits the fixed ALU latency and writes the result/flags back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NREGS   = 4,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [23:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [7:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_x,
  input  logic [7:0]        alu_flags,
  output logic [7:0]        flags_q,
  output logic              done,
  output logic              err,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned CW = $clog2(ALU_LAT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        op_q, op_d;
  logic [1:0]        rd_q, rd_d;
  logic [1:0]        rs_q, rs_d;
  logic [7:0]        sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [7:0]        flg_q, flg_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] rf_rs_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (rd_q),
    .rdata_a_o  (rf_rd_data),
    .raddr_b_i  (rs_q),
    .rdata_b_o  (rf_rs_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    flg_d    = flg_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = alu_x;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (is_alu_op(instr[23:16])) begin
            op_d    = instr[23:16];
            rd_d    = instr[15:14];
            rs_d    = instr[13:12];
            state_d = ST_ISSUE;
          end else if (instr[23:16] == OP_LDI) begin
            // LDI retires directly from IDLE through the write port; the ALU stays idle
            rf_we    = 1'b1;
            rf_waddr = instr[15:14];
            rf_wdata = DATA_W'(instr[7:0]);
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        sel_d   = op_q;
        a_d     = rf_rd_data;
        b_d     = rf_rs_data;
        cnt_d   = CW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CW'(ALU_LAT)) begin
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WB: begin
        flg_d   = alu_flags;
        rf_we   = (op_q != OP_CMP);
        done_d  = 1'b1;
        sel_d   = OP_NOP;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_sel     = sel_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign flags_q     = flg_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a two-stage registered ALU model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  alu_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_x;
  logic [7:0]  alu_flags;
  logic [7:0]  flags_q;
  logic        done;
  logic        err;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .DATA_W  (8),
    .NREGS   (4),
    .ALU_LAT (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_sel     (alu_sel),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_x       (alu_x),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // ALU model: result/flags for sel/a/b, registered twice
  function automatic logic [15:0] alu_fn(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    logic [7:0] f;
    r = '0;
    f = '0;
    case (s)
      8'h01: begin
        r = {1'b0, a} + {1'b0, b};
        f[6] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      8'h02, 8'h0F: begin
        r = {1'b0, a} - {1'b0, b};
        f[6] = (a[7] != b[7]) && (r[7] != a[7]);
      end
      default: return 16'h0000;
    endcase
    f[0] = (r[7:0] == 8'h00);
    f[1] = r[8];
    f[2] = r[7];
    f[3] = ~^r[7:0];
    return {f, r[7:0]};
  endfunction

  logic [15:0] alu_s1, alu_s2;
  always @(posedge clk) begin
    alu_s1 <= alu_fn(alu_sel, alu_a, alu_b);
    alu_s2 <= alu_s1;
  end
  assign alu_x     = alu_s2[7:0];
  assign alu_flags = alu_s2[15:8];

  function automatic logic [23:0] mk(input logic [7:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, 4'h0, imm};
  endfunction

  // Offers ins until accepted; returns #1 after the accepting edge
  task automatic send(input logic [23:0] ins, output bit ok);
    bit rdy;
    ok = 1'b0;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = instr_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1 instr_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      $display("FAIL send_accept: instr=%h not accepted within 20 cycles, required accept", ins);
      n_bad++;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_addr = idx;
    #1 val = dbg_data;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({alu_sel, alu_a, alu_b, flags_q, done, err, instr_ready} !== {32'h0, 3'b001}) begin
      $display("FAIL reset_outputs: sel=%h a=%h b=%h fl=%h done=%b err=%b rdy=%b, required zeros with rdy=1",
               alu_sel, alu_a, alu_b, flags_q, done, err, instr_ready);
      n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      n_cmp++;
      if (v !== 8'h00) begin
        $display("FAIL reset_reg: R%0d=%h, required 00", i, v);
        n_bad++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ldi_add();
    bit ok;
    logic [7:0] v;
    send(mk(8'hC0, 2'd0, 2'd0, 8'h05), ok);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      $display("FAIL ldi_done: done=%b err=%b, required done=1 err=0", done, err);
      n_bad++;
    end
    read_reg(2'd0, v);
    n_cmp++;
    if (v !== 8'h05) begin
      $display("FAIL ldi_r0: R0=%h, required 05", v);
      n_bad++;
    end
    send(mk(8'hC0, 2'd1, 2'd0, 8'h03), ok);
    send(mk(8'h01, 2'd0, 2'd1, 8'h00), ok);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e <= 3) begin
        n_cmp++;
        if (done !== 1'b0 || instr_ready !== 1'b0) begin
          $display("FAIL add_busy: edge %0d done=%b rdy=%b, required 0/0", e, done, instr_ready);
          n_bad++;
        end
      end
      if (e <= 2) begin
        n_cmp++;
        if ({alu_sel, alu_a, alu_b} !== 24'h01_05_03) begin
          $display("FAIL add_operands: edge %0d sel/a/b=%h, required 010503", e, {alu_sel, alu_a, alu_b});
          n_bad++;
        end
      end
    end
    n_cmp++;
    if (done !== 1'b1 || alu_sel !== 8'h00 || flags_q[0] !== 1'b0 || instr_ready !== 1'b1) begin
      $display("FAIL add_retire: done=%b sel=%h fl=%h rdy=%b, required 1/00/Z=0/1", done, alu_sel, flags_q, instr_ready);
      n_bad++;
    end
    read_reg(2'd0, v);
    n_cmp++;
    if (v !== 8'h08) begin
      $display("FAIL add_r0: R0=%h, required 08", v);
      n_bad++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      $display("FAIL add_done_width: done=%b, required 0", done);
      n_bad++;
    end
  endtask

  task automatic test_carry();
    bit ok;
    int cyc;
    logic [7:0] v;
    send(mk(8'hC0, 2'd2, 2'd0, 8'hFF), ok);
    send(mk(8'hC0, 2'd3, 2'd0, 8'h01), ok);
    send(mk(8'h01, 2'd2, 2'd3, 8'h00), ok);
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      $display("FAIL carry_ready: rdy=%b after accept, required 0", instr_ready);
      n_bad++;
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 4) begin
      $display("FAIL carry_latency: %0d cycles, required 4", cyc);
      n_bad++;
    end
    read_reg(2'd2, v);
    n_cmp++;
    if (v !== 8'h00 || flags_q !== 8'h0B || instr_ready !== 1'b1) begin
      $display("FAIL carry_result: R2=%h fl=%h rdy=%b, required 00/0B/1", v, flags_q, instr_ready);
      n_bad++;
    end
  endtask

  task automatic test_cmp();
    bit ok;
    int cyc;
    logic [7:0] v;
    send(mk(8'h0F, 2'd0, 2'd0, 8'h00), ok);
    wait_done(cyc);
    read_reg(2'd0, v);
    n_cmp++;
    if (cyc !== 4 || v !== 8'h08 || flags_q !== 8'h09) begin
      $display("FAIL cmp_result: lat=%0d R0=%h fl=%h, required 4/08/09", cyc, v, flags_q);
      n_bad++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      $display("FAIL cmp_done_once: done=%b, required 0", done);
      n_bad++;
    end
  endtask

  task automatic test_illegal();
    bit ok;
    logic [7:0] v;
    logic [31:0] regs;
    send(mk(8'h0E, 2'd1, 2'd2, 8'hAA), ok);
    n_cmp++;
    if (err !== 1'b1 || done !== 1'b0 || alu_sel !== 8'h00 || instr_ready !== 1'b1) begin
      $display("FAIL illegal_err: err=%b done=%b sel=%h rdy=%b, required 1/0/00/1", err, done, alu_sel, instr_ready);
      n_bad++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b0 || alu_sel !== 8'h00 || flags_q !== 8'h09) begin
      $display("FAIL illegal_after: err=%b sel=%h fl=%h, required 0/00/09", err, alu_sel, flags_q);
      n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      regs[8*i +: 8] = v;
    end
    n_cmp++;
    if (regs !== 32'h01_00_03_08) begin
      $display("FAIL illegal_regs: R3..R0=%h, required 01000308", regs);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit rdy;
    bit acc;
    bit first_done;
    int cyc;
    logic [7:0] v;
    dbg_addr = 2'd0;
    send(mk(8'h01, 2'd0, 2'd1, 8'h00), ok);
    repeat (2) @(posedge clk);
    @(negedge clk);
    instr = mk(8'h01, 2'd0, 2'd1, 8'h00);
    instr_valid = 1'b1;
    n_cmp++;
    if (instr_ready !== 1'b0) begin
      $display("FAIL b2b_held: rdy=%b during WAIT, required 0", instr_ready);
      n_bad++;
    end
    acc = 1'b0;
    first_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdy = instr_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = 1'b1;
        instr_valid = 1'b0;
        break;
      end
      if (done) begin
        first_done = 1'b1;
        n_cmp++;
        if (dbg_data !== 8'h0B) begin
          $display("FAIL b2b_first: R0=%h, required 0B", dbg_data);
          n_bad++;
        end
      end
    end
    instr_valid = 1'b0;
    n_cmp++;
    if (!acc || !first_done) begin
      $display("FAIL b2b_order: accepted=%b first_done=%b, required 1/1", acc, first_done);
      n_bad++;
    end
    wait_done(cyc);
    read_reg(2'd0, v);
    n_cmp++;
    if (cyc !== 4 || v !== 8'h0E || flags_q !== 8'h00) begin
      $display("FAIL b2b_second: lat=%0d R0=%h fl=%h, required 4/0E/00", cyc, v, flags_q);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    bit saw_done;
    logic [7:0] v;
    send(mk(8'h02, 2'd0, 2'd1, 8'h00), ok);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({alu_sel, alu_a, alu_b, flags_q, done, err, instr_ready} !== {32'h0, 3'b001}) begin
      $display("FAIL midrst_outputs: sel=%h a=%h b=%h fl=%h done=%b err=%b rdy=%b, required zeros with rdy=1",
               alu_sel, alu_a, alu_b, flags_q, done, err, instr_ready);
      n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      n_cmp++;
      if (v !== 8'h00) begin
        $display("FAIL midrst_reg: R%0d=%h, required 00", i, v);
        n_bad++;
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    read_reg(2'd0, v);
    n_cmp++;
    if (saw_done || instr_ready !== 1'b1 || v !== 8'h00) begin
      $display("FAIL midrst_after: done_seen=%b rdy=%b R0=%h, required 0/1/00", saw_done, instr_ready, v);
      n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_carry();
    test_cmp();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
